// File: rtl/triangle_pulse_arbiter.sv
// Two-requester dav_/rfd arbiter in front of the triangular-pulse generator.
// Optional build macro ZERO_H_FILTER_EN: descriptors with h=0 are acknowledged but not forwarded.
module triangle_pulse_arbiter #(
  parameter int H_W        = 7,
  parameter int FIXED_PRIO = 0
) (
  input  logic           clock,
  input  logic           reset_,
  input  logic           dav0_,
  input  logic           s0,
  input  logic [H_W-1:0] h0,
  output logic           rfd0,
  input  logic           dav1_,
  input  logic           s1,
  input  logic [H_W-1:0] h1,
  output logic           rfd1,
  output logic           dav_,
  output logic           s,
  output logic [H_W-1:0] h,
  input  logic           rfd,
  output logic           grant,
  output logic           busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_UP_REL  = 2'd1,
    ST_DN_WAIT = 2'd2,
    ST_DN_SEND = 2'd3
  } state_t;

  state_t state_r;
  logic   rr_ptr_r;
  logic   req0_s;
  logic   req1_s;
  logic   pick_s;
  logic   sel_dav_s;
  logic   drop_s;

  // Qualify requests against our own rfd and pick the winner on a tie
  always_comb begin
    req0_s    = 1'b0;
    req1_s    = 1'b0;
    pick_s    = 1'b0;
    sel_dav_s = 1'b1;
    req0_s    = ~dav0_ & rfd0;
    req1_s    = ~dav1_ & rfd1;
    if (req0_s && req1_s) begin
      pick_s = (FIXED_PRIO != 0) ? 1'b0 : rr_ptr_r;
    end else if (req1_s) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
    if (grant) begin
      sel_dav_s = dav1_;
    end else begin
      sel_dav_s = dav0_;
    end
  end

`ifdef ZERO_H_FILTER_EN
  // A zero length would wrap the generator counter into a full-length pulse
  assign drop_s = (h == {H_W{1'b0}});
`else
  assign drop_s = 1'b0;
`endif

  // Capture, upstream release, downstream replay sequencing
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_r  <= ST_IDLE;
      rfd0     <= 1'b0;
      rfd1     <= 1'b0;
      dav_     <= 1'b1;
      s        <= 1'b0;
      h        <= {H_W{1'b0}};
      grant    <= 1'b0;
      busy     <= 1'b0;
      rr_ptr_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rfd0 <= 1'b1;
          rfd1 <= 1'b1;
          if (req0_s || req1_s) begin
            s        <= pick_s ? s1 : s0;
            h        <= pick_s ? h1 : h0;
            grant    <= pick_s;
            busy     <= 1'b1;
            rr_ptr_r <= ~pick_s;
            state_r  <= ST_UP_REL;
            if (pick_s) begin
              rfd1 <= 1'b0;
            end else begin
              rfd0 <= 1'b0;
            end
          end
        end
        ST_UP_REL: begin
          if (sel_dav_s) begin
            if (drop_s) begin
              busy    <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_DN_WAIT;
            end
          end
        end
        ST_DN_WAIT: begin
          if (rfd) begin
            dav_    <= 1'b0;
            state_r <= ST_DN_SEND;
          end
        end
        ST_DN_SEND: begin
          // dav_ rises on the very edge rfd is seen low
          if (!rfd) begin
            dav_    <= 1'b1;
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          dav_    <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_pulse_arbiter.sv
// Directed bench for triangle_pulse_arbiter: round-robin instance plus a fixed-priority instance.
// Expectations for h=0 follow the ZERO_H_FILTER_EN build macro.
module tb_triangle_pulse_arbiter;

  logic       clock;
  logic       reset_;
  logic       dav0_, s0, rfd0, dav1_, s1, rfd1;
  logic [6:0] h0, h1, h;
  logic       dav_, s, rfd, grant, busy;
  logic       fp_dav0_, fp_s0, fp_rfd0, fp_dav1_, fp_s1, fp_rfd1;
  logic [6:0] fp_h0, fp_h1, fp_h;
  logic       fp_dav_, fp_s, fp_rfd, fp_grant, fp_busy;
  int         vec_cnt;
  int         miss_cnt;

  triangle_pulse_arbiter #(.H_W(7), .FIXED_PRIO(0)) u_dut (
    .clock(clock), .reset_(reset_),
    .dav0_(dav0_), .s0(s0), .h0(h0), .rfd0(rfd0),
    .dav1_(dav1_), .s1(s1), .h1(h1), .rfd1(rfd1),
    .dav_(dav_), .s(s), .h(h), .rfd(rfd), .grant(grant), .busy(busy)
  );

  triangle_pulse_arbiter #(.H_W(7), .FIXED_PRIO(1)) u_fp (
    .clock(clock), .reset_(reset_),
    .dav0_(fp_dav0_), .s0(fp_s0), .h0(fp_h0), .rfd0(fp_rfd0),
    .dav1_(fp_dav1_), .s1(fp_s1), .h1(fp_h1), .rfd1(fp_rfd1),
    .dav_(fp_dav_), .s(fp_s), .h(fp_h), .rfd(fp_rfd), .grant(fp_grant), .busy(fp_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // single-requester transfer with the generator already ready
  task automatic send(input logic who, input logic sv, input logic [6:0] hv);
    if (who) begin
      dav1_ = 1'b0; s1 = sv; h1 = hv;
    end else begin
      dav0_ = 1'b0; s0 = sv; h0 = hv;
    end
    tick(1);
    check_vec("send_cap_rfd", 32'(who ? rfd1 : rfd0), 32'd0);
    check_vec("send_grant", 32'(grant), 32'(who));
    dav0_ = 1'b1; dav1_ = 1'b1;
    tick(2);
    check_vec("send_dav", 32'(dav_), 32'd0);
    check_vec("send_h", 32'(h), 32'(hv));
    rfd = 1'b0;
    tick(1);
    check_vec("send_end_dav", 32'(dav_), 32'd1);
    rfd = 1'b1;
    tick(1);
  endtask

  // both requesters low on the same edge; 'first' is the expected winner
  task automatic tie(input logic first, input logic [6:0] ha, input logic [6:0] hb);
    dav0_ = 1'b0; s0 = 1'b0; h0 = ha;
    dav1_ = 1'b0; s1 = 1'b1; h1 = hb;
    tick(1);
    check_vec("tie_grant_a", 32'(grant), 32'(first));
    check_vec("tie_loser_rfd", 32'(first ? rfd0 : rfd1), 32'd1);
    if (first) dav1_ = 1'b1; else dav0_ = 1'b1;
    tick(2);
    check_vec("tie_h_a", 32'(h), 32'(first ? hb : ha));
    check_vec("tie_s_a", 32'(s), 32'(first));
    rfd = 1'b0;
    tick(1);
    check_vec("tie_end_a", 32'(dav_), 32'd1);
    rfd = 1'b1;
    tick(1);
    check_vec("tie_grant_b", 32'(grant), 32'(!first));
    if (first) dav0_ = 1'b1; else dav1_ = 1'b1;
    tick(2);
    check_vec("tie_h_b", 32'(h), 32'(first ? ha : hb));
    rfd = 1'b0;
    tick(1);
    rfd = 1'b1;
    tick(1);
  endtask

  initial begin
    logic ok;
    vec_cnt = 0; miss_cnt = 0;
    reset_ = 1'b0;
    dav0_ = 1'b1; s0 = 1'b0; h0 = 7'd0; dav1_ = 1'b1; s1 = 1'b0; h1 = 7'd0; rfd = 1'b1;
    fp_dav0_ = 1'b1; fp_s0 = 1'b0; fp_h0 = 7'd0; fp_dav1_ = 1'b1; fp_s1 = 1'b0; fp_h1 = 7'd0;
    fp_rfd = 1'b1;
    #12;
    check_vec("rst_rfd0", 32'(rfd0), 32'd0);
    check_vec("rst_rfd1", 32'(rfd1), 32'd0);
    check_vec("rst_dav", 32'(dav_), 32'd1);
    check_vec("rst_busy", 32'(busy), 32'd0);
    check_vec("rst_h", 32'(h), 32'd0);
    @(negedge clock);
    reset_ = 1'b1;
    tick(1);
    check_vec("idle_rfd0", 32'(rfd0), 32'd1);
    check_vec("idle_rfd1", 32'(rfd1), 32'd1);

    // req0 alone, s=0 h=5, cycle-exact
    dav0_ = 1'b0; s0 = 1'b0; h0 = 7'd5;
    tick(1);
    check_vec("r0_rfd0_fall", 32'(rfd0), 32'd0);
    check_vec("r0_busy", 32'(busy), 32'd1);
    check_vec("r0_dav_early", 32'(dav_), 32'd1);
    dav0_ = 1'b1;
    tick(1);
    check_vec("r0_dav_wait", 32'(dav_), 32'd1);
    tick(1);
    check_vec("r0_dav_low", 32'(dav_), 32'd0);
    check_vec("r0_s", 32'(s), 32'd0);
    check_vec("r0_h", 32'(h), 32'd5);
    check_vec("r0_grant", 32'(grant), 32'd0);
    rfd = 1'b0;
    tick(1);
    check_vec("r0_dav_rise", 32'(dav_), 32'd1);
    check_vec("r0_busy_clr", 32'(busy), 32'd0);
    check_vec("r0_rfd0_still_low", 32'(rfd0), 32'd0);
    rfd = 1'b1;
    tick(1);
    check_vec("r0_rfd0_back", 32'(rfd0), 32'd1);
    check_vec("r0_h_kept", 32'(h), 32'd5);

    // generator busy for 20 cycles while req1 (s=1 h=9) waits
    rfd = 1'b0;
    dav1_ = 1'b0; s1 = 1'b1; h1 = 7'd9;
    tick(1);
    check_vec("r1_rfd1_fall", 32'(rfd1), 32'd0);
    check_vec("r1_grant", 32'(grant), 32'd1);
    dav1_ = 1'b1; s1 = 1'b0; h1 = 7'd0;
    tick(1);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (dav_ !== 1'b1 || s !== 1'b1 || h !== 7'd9 || busy !== 1'b1) ok = 1'b0;
    end
    check_vec("dn_wait_hold", 32'(ok), 32'd1);
    rfd = 1'b1;
    tick(1);
    check_vec("dn_wait_fwd_dav", 32'(dav_), 32'd0);
    check_vec("dn_wait_fwd_h", 32'(h), 32'd9);
    check_vec("dn_wait_fwd_s", 32'(s), 32'd1);
    rfd = 1'b0;
    tick(1);
    check_vec("dn_wait_end", 32'(dav_), 32'd1);
    rfd = 1'b1;
    tick(1);

    // req0 holds dav0_ low for 10 cycles after capture
    dav0_ = 1'b0; s0 = 1'b1; h0 = 7'd7;
    tick(1);
    check_vec("hold_cap", 32'(rfd0), 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (dav_ !== 1'b1 || busy !== 1'b1 || rfd0 !== 1'b0) ok = 1'b0;
    end
    check_vec("hold_up_rel", 32'(ok), 32'd1);
    dav0_ = 1'b1;
    tick(2);
    check_vec("hold_fwd_dav", 32'(dav_), 32'd0);
    check_vec("hold_fwd_h", 32'(h), 32'd7);
    rfd = 1'b0;
    tick(1);
    rfd = 1'b1;
    tick(1);

    // req1 with h=0
    dav1_ = 1'b0; s1 = 1'b0; h1 = 7'd0;
    tick(1);
    check_vec("zh_cap", 32'(rfd1), 32'd0);
    dav1_ = 1'b1;
    tick(1);
`ifdef ZERO_H_FILTER_EN
    check_vec("zh_busy_clr", 32'(busy), 32'd0);
    tick(1);
    check_vec("zh_no_dav", 32'(dav_), 32'd1);
    check_vec("zh_rfd1_back", 32'(rfd1), 32'd1);
    tick(2);
    check_vec("zh_no_dav_late", 32'(dav_), 32'd1);
`else
    tick(1);
    check_vec("zh_fwd_dav", 32'(dav_), 32'd0);
    check_vec("zh_fwd_h", 32'(h), 32'd0);
    rfd = 1'b0;
    tick(1);
    rfd = 1'b1;
    tick(1);
`endif

    // reset pulsed mid-DN_SEND
    dav0_ = 1'b0; s0 = 1'b1; h0 = 7'd6;
    tick(1);
    dav0_ = 1'b1;
    tick(2);
    check_vec("mr_in_send", 32'(dav_), 32'd0);
    #2 reset_ = 1'b0;
    #1;
    check_vec("mr_rfd0", 32'(rfd0), 32'd0);
    check_vec("mr_rfd1", 32'(rfd1), 32'd0);
    check_vec("mr_dav", 32'(dav_), 32'd1);
    check_vec("mr_busy", 32'(busy), 32'd0);
    check_vec("mr_h", 32'(h), 32'd0);
    check_vec("mr_grant", 32'(grant), 32'd0);
    @(negedge clock);
    reset_ = 1'b1;
    tick(1);
    check_vec("mr_idle_rfd0", 32'(rfd0), 32'd1);
    check_vec("mr_idle_rfd1", 32'(rfd1), 32'd1);
    check_vec("mr_idle_dav", 32'(dav_), 32'd1);

    // round-robin ties: pointer 0 after reset -> req0 first; after a lone req0 -> req1 first
    tie(1'b0, 7'd3, 7'd4);
    send(1'b0, 1'b0, 7'd2);
    tie(1'b1, 7'd3, 7'd4);

    // fixed priority: req0 wins a tie even when the pointer favours req1
    fp_dav0_ = 1'b0; fp_s0 = 1'b0; fp_h0 = 7'd1;
    tick(1);
    check_vec("fp_single_grant", 32'(fp_grant), 32'd0);
    fp_dav0_ = 1'b1;
    tick(2);
    fp_rfd = 1'b0;
    tick(1);
    fp_rfd = 1'b1;
    tick(1);
    fp_dav0_ = 1'b0; fp_h0 = 7'd3; fp_dav1_ = 1'b0; fp_s1 = 1'b1; fp_h1 = 7'd4;
    tick(1);
    check_vec("fp_tie_grant", 32'(fp_grant), 32'd0);
    fp_dav0_ = 1'b1;
    tick(2);
    check_vec("fp_tie_h_a", 32'(fp_h), 32'd3);
    fp_rfd = 1'b0;
    tick(1);
    fp_rfd = 1'b1;
    tick(1);
    check_vec("fp_tie_grant_b", 32'(fp_grant), 32'd1);
    fp_dav1_ = 1'b1;
    tick(2);
    check_vec("fp_tie_h_b", 32'(fp_h), 32'd4);
    fp_rfd = 1'b0;
    tick(1);
    fp_rfd = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
